// File: rtl/cpu_pkg.sv
// cpu_pkg: shared word type, NOP encoding and fetch FSM states
package cpu_pkg;
    typedef logic [31:0] word_t;
    localparam word_t NOP_INSTR = 32'h0000_0013;
    typedef enum logic [1:0] {BOOT, RUN, FLUSH} fetch_state_e;
endpackage

// File: rtl/instr_queue.sv
// instr_queue: in-order FIFO of {pc, instr} with flush and occupancy count
module instr_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [31:0]      push_pc,
    input  logic [31:0]      push_instr,
    input  logic             pop,
    output logic [31:0]      head_pc,
    output logic [31:0]      head_instr,
    output logic [CNT_W-1:0] count
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    word_t pcs [DEPTH];
    word_t instrs [DEPTH];
    logic [PW-1:0] rd, wr;
    logic empty, do_push, do_pop;
    always_comb begin
        empty = count == '0;
        do_pop = pop && !empty;
        do_push = push && (count != CNT_W'(DEPTH) || do_pop);
        head_pc = empty ? '0 : pcs[rd];
        head_instr = empty ? NOP_INSTR : instrs[rd];
    end
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd <= '0;
            wr <= '0;
            count <= '0;
        end else begin
            rd <= do_pop ? (rd == LAST ? '0 : rd + 1'b1) : rd;
            wr <= do_push ? (wr == LAST ? '0 : wr + 1'b1) : wr;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            pcs[wr] <= push_pc;
            instrs[wr] <= push_instr;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencing, imem request gating, response queueing and redirect flush
module fetch_unit
    import cpu_pkg::*;
#(
    parameter word_t RESET_PC    = 32'h0000_0000,
    parameter int    QUEUE_DEPTH = 2,
    parameter int    CNT_W       = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] Instr,
    output logic [31:0] instr_pc
);
    fetch_state_e state;
    word_t fetch_pc, rsp_pc, target;
    logic [CNT_W-1:0] outst, drop, outst_next, drop_next, count;
    logic accept, rsp_ok, push, pop;
    // a response with nothing outstanding is a leftover from before reset
    always_comb begin
        target = redirect_pc & 32'hFFFF_FFFC;
        rsp_ok = imem_rsp_valid && outst != '0;
        imem_req_valid = state != BOOT && !redirect &&
                         ({1'b0, outst} + {1'b0, count} < (CNT_W + 1)'(QUEUE_DEPTH));
        imem_req_addr = fetch_pc;
        accept = imem_req_valid && imem_req_ready;
        push = rsp_ok && drop == '0 && !redirect;
        instr_valid = count != '0 && !redirect;
        pop = instr_valid && instr_ready;
        outst_next = outst + CNT_W'(accept) - CNT_W'(rsp_ok);
        drop_next = redirect ? outst - CNT_W'(rsp_ok) : drop - CNT_W'(rsp_ok && drop != '0);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BOOT;
            fetch_pc <= RESET_PC;
            rsp_pc <= RESET_PC;
            outst <= '0;
            drop <= '0;
        end else begin
            outst <= outst_next;
            drop <= drop_next;
            fetch_pc <= redirect ? target : accept ? fetch_pc + 32'd4 : fetch_pc;
            rsp_pc <= redirect ? target : push ? rsp_pc + 32'd4 : rsp_pc;
            state <= state == BOOT ? RUN :
                     (state == RUN && redirect && outst != '0) ? FLUSH :
                     (state == FLUSH && drop_next == '0) ? RUN : state;
        end
    end
    instr_queue #(.DEPTH(QUEUE_DEPTH), .CNT_W(CNT_W)) u_queue (
        .clk(clk),
        .rst(rst),
        .flush(redirect),
        .push(push),
        .push_pc(rsp_pc),
        .push_instr(imem_rsp_data),
        .pop(pop),
        .head_pc(instr_pc),
        .head_instr(Instr),
        .count(count)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed table trace plus hand sequences against a latency-configurable memory model
module tb_fetch_unit;
    logic clk = 0, rst = 1;
    logic imem_req_valid, imem_req_ready = 1;
    logic [31:0] imem_req_addr;
    logic imem_rsp_valid = 0;
    logic [31:0] imem_rsp_data = 0;
    logic redirect = 0;
    logic [31:0] redirect_pc = 0;
    logic instr_valid, instr_ready = 0;
    logic [31:0] Instr, instr_pc;
    fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .Instr(Instr), .instr_pc(instr_pc)
    );
    always #5 clk = ~clk;
    typedef struct { logic [31:0] addr; int due; } pend_t;
    typedef struct { logic rdy; logic rv; logic [31:0] addr; logic iv; logic [31:0] pc; } vec_t;
    pend_t pend[$];
    logic [31:0] dpc[$], din[$], aq[$];
    vec_t tbl[8];
    int checks = 0, errors = 0, cyc = 0, lat = 1, last_due = 0, nacc = 0;
    logic man = 0;
    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction
    function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
        return i < q.size() ? q[i] : 32'hFFFF_FFFF;
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic tick();
        logic acc;
        logic [31:0] a;
        int due;
        acc = imem_req_valid && imem_req_ready;
        a = imem_req_addr;
        if (instr_valid) chk("instr_data", Instr, mem(instr_pc));
        if (instr_valid && instr_ready) begin
            dpc.push_back(instr_pc);
            din.push_back(Instr);
        end
        if (acc) begin
            nacc++;
            aq.push_back(a);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (acc) begin
            due = cyc - 1 + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend.push_back('{a, due});
        end
        if (!man) begin
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                imem_rsp_valid = 1;
                imem_rsp_data = mem(pend[0].addr);
                void'(pend.pop_front());
            end else
                imem_rsp_valid = 0;
        end
        #1;
    endtask
    task automatic do_reset(input int l);
        man = 1;
        rst = 1;
        redirect = 0;
        imem_rsp_valid = 0;
        tick();
        tick();
        pend.delete();
        last_due = 0;
        rst = 0;
        lat = l;
        dpc.delete();
        din.delete();
        aq.delete();
        nacc = 0;
        man = 0;
        #1;
    endtask
    task automatic run_until(input int n);
        int k = 0;
        while (dpc.size() < n && k < 30) begin
            tick();
            k++;
        end
        chk("delivery_count", dpc.size(), n);
    endtask
    initial begin
        // BOOT cycle then steady 1-cycle-memory trace
        tbl[0] = '{0, 0, 32'h0,  0, 32'h0};
        tbl[1] = '{1, 1, 32'h0,  0, 32'h0};
        tbl[2] = '{1, 1, 32'h4,  0, 32'h0};
        tbl[3] = '{1, 0, 32'h8,  1, 32'h0};
        tbl[4] = '{1, 1, 32'h8,  1, 32'h4};
        tbl[5] = '{1, 1, 32'hC,  0, 32'h0};
        tbl[6] = '{1, 0, 32'h10, 1, 32'h8};
        tbl[7] = '{1, 1, 32'h10, 1, 32'hC};
        do_reset(1);
        chk("reset_instr_nop", Instr, 32'h0000_0013);
        chk("reset_instr_pc", instr_pc, 32'h0);
        for (int i = 0; i < 8; i++) begin
            instr_ready = tbl[i].rdy;
            #1;
            chk($sformatf("t1_req_valid[%0d]", i), 32'(imem_req_valid), 32'(tbl[i].rv));
            chk($sformatf("t1_req_addr[%0d]", i), imem_req_addr, tbl[i].addr);
            chk($sformatf("t1_instr_valid[%0d]", i), 32'(instr_valid), 32'(tbl[i].iv));
            if (tbl[i].iv) chk($sformatf("t1_instr_pc[%0d]", i), instr_pc, tbl[i].pc);
            tick();
        end
        // decode stall: only two requests fit
        do_reset(1);
        instr_ready = 0;
        #1;
        for (int i = 0; i < 10; i++) tick();
        chk("t2_accepts", nacc, 2);
        chk("t2_req_valid", 32'(imem_req_valid), 0);
        chk("t2_head_valid", 32'(instr_valid), 1);
        chk("t2_head_pc", instr_pc, 32'h0);
        instr_ready = 1;
        #1;
        run_until(3);
        chk("t2_pc0", at(dpc, 0), 32'h0);
        chk("t2_pc1", at(dpc, 1), 32'h4);
        chk("t2_pc2", at(dpc, 2), 32'h8);
        // redirect with two stale requests in flight
        do_reset(3);
        instr_ready = 1;
        #1;
        for (int i = 0; i < 3; i++) tick();
        chk("t3_full_gate", 32'(imem_req_valid), 0);
        dpc.delete();
        din.delete();
        aq.delete();
        redirect = 1;
        redirect_pc = 32'h0000_0102;
        #1;
        chk("t3_redir_iv", 32'(instr_valid), 0);
        tick();
        redirect = 0;
        #1;
        run_until(1);
        chk("t3_first_addr", at(aq, 0), 32'h100);
        chk("t3_first_pc", at(dpc, 0), 32'h100);
        chk("t3_first_instr", at(din, 0), mem(32'h100));
        // redirect alongside a response, a push and a pop
        do_reset(1);
        instr_ready = 1;
        #1;
        for (int i = 0; i < 3; i++) tick();
        chk("t4a_pre_iv", 32'(instr_valid), 1);
        chk("t4a_pre_rsp", 32'(imem_rsp_valid), 1);
        dpc.delete();
        aq.delete();
        redirect = 1;
        redirect_pc = 32'h200;
        #1;
        chk("t4a_redir_req", 32'(imem_req_valid), 0);
        tick();
        redirect = 0;
        #1;
        chk("t4a_empty", 32'(instr_valid), 0);
        chk("t4a_req_valid", 32'(imem_req_valid), 1);
        chk("t4a_req_addr", imem_req_addr, 32'h200);
        run_until(1);
        chk("t4a_first_pc", at(dpc, 0), 32'h200);
        do_reset(2);
        instr_ready = 1;
        #1;
        for (int i = 0; i < 3; i++) tick();
        chk("t4b_pre_rsp", 32'(imem_rsp_valid), 1);
        dpc.delete();
        redirect = 1;
        redirect_pc = 32'h300;
        #1;
        tick();
        redirect = 0;
        #1;
        chk("t4b_req_addr", imem_req_addr, 32'h300);
        run_until(1);
        chk("t4b_first_pc", at(dpc, 0), 32'h300);
        // PC wrap from the top of the address space
        do_reset(1);
        instr_ready = 1;
        redirect = 1;
        redirect_pc = 32'hFFFF_FFFC;
        #1;
        tick();
        redirect = 0;
        #1;
        chk("t5_addr_top", imem_req_addr, 32'hFFFF_FFFC);
        tick();
        chk("t5_addr_wrap", imem_req_addr, 32'h0);
        run_until(2);
        chk("t5_pc0", at(dpc, 0), 32'hFFFF_FFFC);
        chk("t5_pc1", at(dpc, 1), 32'h0);
        // reset with requests in flight, late responses afterwards
        do_reset(3);
        instr_ready = 1;
        #1;
        for (int i = 0; i < 3; i++) tick();
        man = 1;
        rst = 1;
        #1;
        tick();
        pend.delete();
        rst = 0;
        #1;
        chk("t6_boot_req", 32'(imem_req_valid), 0);
        chk("t6_boot_iv", 32'(instr_valid), 0);
        chk("t6_boot_instr", Instr, 32'h0000_0013);
        chk("t6_boot_pc", instr_pc, 32'h0);
        imem_rsp_valid = 1;
        imem_rsp_data = 32'hBAD0_0001;
        #1;
        tick();
        imem_rsp_data = 32'hBAD0_0002;
        #1;
        chk("t6_restart_req", 32'(imem_req_valid), 1);
        chk("t6_restart_addr", imem_req_addr, 32'h0);
        lat = 1;
        last_due = 0;
        dpc.delete();
        din.delete();
        man = 0;
        run_until(1);
        chk("t6_first_pc", at(dpc, 0), 32'h0);
        chk("t6_first_instr", at(din, 0), mem(32'h0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
